// File: rtl/rfs_wifi_mem_pkg.sv
// Shared constants and types for the two-master Wi-Fi memory arbiter.
package rfs_wifi_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 15;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 32500;

  // Outstanding read: valid plus the index of the master that owns the response.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rfs_wifi_rr_arb2.sv
// Two-way round-robin grant (combinational) with a registered priority pointer.
module rfs_wifi_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c
);

  logic rr_q;
  logic rr_d;

  // Grant a lone requester; on contention grant rr and hand priority to the loser.
  always_comb begin
    gnt_c = 2'b00;
    rr_d  = rr_q;
    if (req_i == 2'b11) begin
      gnt_c = rr_q ? 2'b10 : 2'b01;
      rr_d  = ~rr_q;
    end else begin
      gnt_c = req_i;
    end
  end

  // Pointer register; master 0 favoured out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/rfs_wifi_mem_arbiter.sv
// Two-master single-port memory arbiter with 1-cycle read return routing.
// Optional address range checking is enabled by defining RFS_WIFI_ARB_OOR_CHECK_EN.
module rfs_wifi_mem_arbiter
  import rfs_wifi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oor,
  input  logic                err_clr
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]        req_raw_c;
  logic [1:0]        req_c;
  logic [1:0]        gnt_c;
  logic              any_gnt_c;
  logic              sel_wr_c;
  logic              sel_rd_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [BE_W-1:0]   sel_be_c;
  logic [DATA_W-1:0] sel_wd_c;
  logic              addr_hi_c;
  logic              oor_c;
  logic              rd_zero_c;
  rd_tag_t           tag_q;
  rd_tag_t           tag_d;

  assign req_raw_c = {m1_read | m1_write, m0_read | m0_write};
  // No grant is issued while reset is held, so nothing reaches memory or the tag.
  assign req_c     = req_raw_c & {2{~reset}};

  rfs_wifi_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req_i (req_c),
    .gnt_c (gnt_c)
  );

  assign any_gnt_c      = |gnt_c;
  assign m0_waitrequest = req_raw_c[0] & ~gnt_c[0];
  assign m1_waitrequest = req_raw_c[1] & ~gnt_c[1];

  // Select the granted master's request; read+write together counts as a write.
  always_comb begin
    sel_wr_c   = m0_write;
    sel_rd_c   = m0_read & ~m0_write;
    sel_addr_c = m0_address;
    sel_be_c   = m0_byteenable;
    sel_wd_c   = m0_writedata;
    if (gnt_c[1]) begin
      sel_wr_c   = m1_write;
      sel_rd_c   = m1_read & ~m1_write;
      sel_addr_c = m1_address;
      sel_be_c   = m1_byteenable;
      sel_wd_c   = m1_writedata;
    end
  end

  assign addr_hi_c = 32'(sel_addr_c) >= 32'(DEPTH);

`ifdef RFS_WIFI_ARB_OOR_CHECK_EN
  logic oor_rd_q;
  logic oor_rd_d;
  logic err_oor_q;
  logic err_oor_d;

  assign oor_c     = any_gnt_c & addr_hi_c;
  assign rd_zero_c = oor_rd_q;
  assign err_oor   = err_oor_q;

  // Out-of-range bookkeeping: zero the returned data and keep a sticky error (set wins).
  always_comb begin
    oor_rd_d  = oor_c & sel_rd_c;
    err_oor_d = err_oor_q;
    if (err_clr) err_oor_d = 1'b0;
    if (oor_c)   err_oor_d = 1'b1;
  end

  // Out-of-range state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oor_rd_q  <= 1'b0;
      err_oor_q <= 1'b0;
    end else begin
      oor_rd_q  <= oor_rd_d;
      err_oor_q <= err_oor_d;
    end
  end
`else
  logic unused_c;

  assign oor_c     = 1'b0;
  assign rd_zero_c = 1'b0;
  assign err_oor   = 1'b0;
  assign unused_c  = err_clr ^ addr_hi_c;
`endif

  assign mem_chipselect = any_gnt_c & ~oor_c;
  assign mem_write      = mem_chipselect & sel_wr_c;
  assign mem_address    = any_gnt_c ? sel_addr_c : '0;
  assign mem_byteenable = any_gnt_c ? sel_be_c   : '0;
  assign mem_writedata  = any_gnt_c ? sel_wd_c   : '0;

  // Tag the granted read so its response is routed to the owner next cycle.
  always_comb begin
    tag_d       = '0;
    tag_d.valid = any_gnt_c & sel_rd_c;
    tag_d.owner = gnt_c[1];
  end

  // Read tag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  assign m0_readdatavalid = tag_q.valid & ~tag_q.owner;
  assign m1_readdatavalid = tag_q.valid &  tag_q.owner;
  assign m0_readdata      = (m0_readdatavalid & ~rd_zero_c) ? mem_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid & ~rd_zero_c) ? mem_readdata : '0;

endmodule

// File: tb/tb_rfs_wifi_mem_arbiter.sv
// Scoreboard bench for rfs_wifi_mem_arbiter; range-check cases follow RFS_WIFI_ARB_OOR_CHECK_EN.
module tb_rfs_wifi_mem_arbiter;

  localparam int unsigned DEPTH = 32500;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [14:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        err_oor, err_clr;

  bit [31:0] mem_arr [0:32767];
  bit [31:0] ref_mem [0:32767];
  rsp_t      sb [$];
  logic      rr_m;
  logic      err_m;
  int        n_cmp = 0;
  int        n_err = 0;

  rfs_wifi_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .err_oor(err_oor), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Single-port memory with byte lanes and 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem_arr[mem_address];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One bus cycle: check last cycle's response, apply new requests, check grant, predict response.
  task automatic drive(input logic r0, input logic w0, input logic [14:0] a0,
                       input logic [3:0] be0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [14:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1, input logic clr);
    rsp_t        e;
    logic        q0, q1, g0, g1, sw, sr, oor;
    logic [14:0] sa;
    logic [3:0]  sbe;
    logic [31:0] sd;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("m0_rdv",   32'(m0_readdatavalid), 32'(e.v0));
      check_eq("m1_rdv",   32'(m1_readdatavalid), 32'(e.v1));
      check_eq("m0_rdata", m0_readdata, e.v0 ? e.d : 32'h0);
      check_eq("m1_rdata", m1_readdata, e.v1 ? e.d : 32'h0);
    end
    check_eq("err_oor", 32'(err_oor), 32'(err_m));
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    err_clr = clr;
    #1;
    q0 = r0 | w0;
    q1 = r1 | w1;
    g0 = q0 && (!q1 || !rr_m);
    g1 = q1 && (!q0 || rr_m);
    if (q0 && q1) rr_m = g0;
    sw  = g1 ? w1 : w0;
    sr  = g1 ? (r1 && !w1) : (r0 && !w0);
    sa  = g1 ? a1 : a0;
    sbe = g1 ? be1 : be0;
    sd  = g1 ? d1 : d0;
    oor = 1'b0;
`ifdef RFS_WIFI_ARB_OOR_CHECK_EN
    oor = (g0 || g1) && (32'(sa) >= DEPTH);
`endif
    check_eq("m0_wait", 32'(m0_waitrequest), 32'(q0 && !g0));
    check_eq("m1_wait", 32'(m1_waitrequest), 32'(q1 && !g1));
    check_eq("mem_cs",  32'(mem_chipselect), 32'((g0 || g1) && !oor));
    check_eq("mem_wr",  32'(mem_write), 32'((g0 || g1) && !oor && sw));
    check_eq("mem_addr", 32'(mem_address), (g0 || g1) ? 32'(sa) : 32'h0);
    check_eq("mem_wdata", mem_writedata, (g0 || g1) ? sd : 32'h0);
    if ((g0 || g1) && sw && !oor)
      for (int b = 0; b < 4; b++)
        if (sbe[b]) ref_mem[sa][8*b +: 8] = sd[8*b +: 8];
    e.v0 = g0 && sr;
    e.v1 = g1 && sr;
    e.d  = (sr && !oor) ? ref_mem[sa] : 32'h0;
    sb.push_back(e);
`ifdef RFS_WIFI_ARB_OOR_CHECK_EN
    if (clr) err_m = 1'b0;
    if (oor) err_m = 1'b1;
`endif
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  initial begin
    rr_m  = 1'b0;
    err_m = 1'b0;
    reset = 1'b1;
    m0_read = 1'b1; m0_write = 1'b0; m0_address = 15'h10; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;    m1_byteenable = '0;   m1_writedata = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_m0_rdv", 32'(m0_readdatavalid), 32'h0);
    check_eq("rst_m1_rdv", 32'(m1_readdatavalid), 32'h0);
    check_eq("rst_m0_rdata", m0_readdata, 32'h0);
    check_eq("rst_cs", 32'(mem_chipselect), 32'h0);
    check_eq("rst_wr", 32'(mem_write), 32'h0);
    check_eq("rst_err", 32'(err_oor), 32'h0);
    m0_read = 1'b0;
    reset   = 1'b0;

    // Single master write then read.
    drive(0, 1, 15'h0010, 4'hF, 32'hDEADBEEF, 0, 0, '0, '0, '0, 0);
    drive(1, 0, 15'h0010, 4'hF, '0,           0, 0, '0, '0, '0, 0);
    idle();

    // Byte lanes over an all-ones word.
    drive(0, 1, 15'h0020, 4'hF, 32'hFFFFFFFF, 0, 0, '0, '0, '0, 0);
    drive(0, 0, '0, '0, '0, 0, 1, 15'h0020, 4'h5, 32'h11223344, 0);
    drive(0, 0, '0, '0, '0, 1, 0, 15'h0020, 4'hF, '0, 0);
    idle();

    // Read+write together is a write; both-write contention.
    drive(1, 1, 15'h0030, 4'hF, 32'hA5A5_0001, 0, 0, '0, '0, '0, 0);
    drive(0, 1, 15'h0031, 4'hF, 32'h0000_0031, 0, 1, 15'h0032, 4'hF, 32'h0000_0032, 0);
    drive(0, 1, 15'h0031, 4'hF, 32'h0000_0031, 0, 0, '0, '0, '0, 0);
    drive(1, 0, 15'h0030, 4'hF, '0, 1, 0, 15'h0032, 4'hF, '0, 0);
    drive(0, 0, '0, '0, '0, 1, 0, 15'h0031, 4'hF, '0, 0);
    idle();

    // Out of range: read, clear, and set-with-clear.
    drive(0, 0, '0, '0, '0, 1, 0, 15'(DEPTH), 4'hF, '0, 0);
    idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1);
    idle();
    drive(0, 1, 15'(DEPTH + 1), 4'hF, 32'hBAD0BAD0, 0, 0, '0, '0, '0, 1);
    idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0, 1);
    drive(1, 0, 15'(DEPTH - 1), 4'hF, '0, 0, 0, '0, '0, '0, 0);
    idle();

    // Reset asserted in the grant cycle of an m0 read.
    drive(1, 0, 15'h0010, 4'hF, '0, 0, 0, '0, '0, '0, 0);
    reset = 1'b1;
    sb.delete();
    rr_m  = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
    check_eq("rstmid_m0_rdv", 32'(m0_readdatavalid), 32'h0);
    check_eq("rstmid_cs", 32'(mem_chipselect), 32'h0);
    m0_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle();
    check_eq("rstrel_m0_rdv", 32'(m0_readdatavalid), 32'h0);

    // Contention for 6 cycles after reset: m0 must win first, then alternate.
    for (int i = 0; i < 6; i++)
      drive(1, 0, 15'h0010, 4'hF, '0, 1, 0, 15'h0020, 4'hF, '0, 0);

    // Random mixed traffic.
    for (int i = 0; i < 40; i++)
      drive(1'($urandom), 1'($urandom), 15'($urandom_range(0, 7)), 4'($urandom), $urandom,
            1'($urandom), 1'($urandom), 15'($urandom_range(0, 7)), 4'($urandom), $urandom, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rfs_wifi_mem_arbiter.md
RFS_WIFI_MEM_ARBITER -- requirements
Module: rfs_wifi_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 15, word-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- DEPTH, 32500, number of valid memory words.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-high reset.
- mX_read (X = 0, 1), in, 1, read request.
- mX_write, in, 1, write request.
- mX_address, in, ADDR_W, word address.
- mX_byteenable, in, DATA_W/8, byte lanes.
- mX_writedata, in, DATA_W, write data.
- mX_waitrequest, out, 1, request not accepted this cycle.
- mX_readdata, out, DATA_W, read data.
- mX_readdatavalid, out, 1, read data valid.
- mem_chipselect, out, 1, memory select.
- mem_write, out, 1, memory write.
- mem_address, out, ADDR_W, memory address.
- mem_byteenable, out, DATA_W/8, memory byte lanes.
- mem_writedata, out, DATA_W, memory write data.
- mem_readdata, in, DATA_W, memory read data; 1-cycle read latency.
- err_oor, out, 1, sticky out-of-range flag.
- err_clr, in, 1, clears err_oor.

Function
REQ-003 A request SHALL be mX_read | mX_write; asserting both at once SHALL be treated as a write.
REQ-004 Grant SHALL be combinational, at most one master per cycle:
- a lone requester is granted;
- when both request, the master named by the round-robin pointer rr is granted.
REQ-005 mX_waitrequest SHALL equal request & ~grantX; it SHALL be 0 when mX is idle.
REQ-006 The master SHALL hold its request and qualifiers stable until it samples waitrequest = 0; the arbiter SHALL NOT depend on this for correctness.
REQ-007 After any cycle in which both masters request, rr SHALL point to the master not granted; otherwise rr SHALL be unchanged.
REQ-008 Memory-side outputs:
- mem_* SHALL mirror the granted master's signals in the grant cycle.
- mem_chipselect = 1 only when a grant is issued.
- With no grant, mem_address, mem_byteenable and mem_writedata SHALL be 0.
REQ-009 The arbiter SHALL keep a registered read tag {valid, owner}, set in the cycle a read is granted.
REQ-010 In the cycle after a granted read:
- mOwner_readdatavalid SHALL be 1;
- mOwner_readdata SHALL be mem_readdata;
- the other master's readdata SHALL be 0.
REQ-011 Back-to-back reads, from the same or alternating masters, SHALL be accepted every cycle, each answered exactly one cycle later; throughput is 1 transaction per cycle.
REQ-012 Writes SHALL complete in the grant cycle and SHALL produce no readdatavalid.
REQ-013 Simultaneous err_clr and a new out-of-range event SHALL leave err_oor = 1 (set wins).

Reset
REQ-014 While reset is 1, all of the following SHALL be 0: rr (master 0 favoured), read tag, all readdatavalid, all readdata, err_oor, mem_chipselect, mem_write.
REQ-015 Reset SHALL take effect asynchronously and release synchronously to clk.
REQ-016 A read granted in the cycle reset asserts SHALL NOT produce readdatavalid after reset release.

Configuration
REQ-017 Macro RFS_WIFI_ARB_OOR_CHECK_EN SHALL control address range checking.
- Defined: a granted access with address >= DEPTH SHALL be accepted (waitrequest = 0) but SHALL keep mem_chipselect = 0. Such a write SHALL be dropped. Such a read SHALL return readdatavalid = 1 with readdata = 0 one cycle later. err_oor SHALL set the following cycle.
- Undefined: no range check is made; err_oor SHALL be tied to 0 and err_clr ignored.

Structure
REQ-018 A shared package rfs_wifi_mem_pkg SHALL hold:
- default ADDR_W, DATA_W and DEPTH constants;
- a read-tag struct typedef {valid, owner}.
REQ-019 A sub-module rfs_wifi_rr_arb2 (2-way round-robin grant plus pointer) SHALL be instantiated once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single master: m0 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 -> m0_readdatavalid one cycle after grant with 0xDEADBEEF; m1 sees no valid.
- Contention: m0 and m1 both read every cycle for 6 cycles after reset -> grants alternate m0, m1, m0, ...; each valid is routed to its owner; waitrequest = 1 on the loser.
- Byte lanes: write 0x11223344 with byteenable 0x5 over 0xFFFFFFFF -> readback 0xFF22FF44.
- Out of range (macro defined): m1 reads 32500 -> readdatavalid with 0; mem_chipselect stays 0; err_oor = 1 next cycle; err_clr clears it; set and clear in the same cycle keep it 1.
- Reset mid-read: assert reset in the grant cycle of an m0 read -> no readdatavalid afterwards; rr = 0 after release.
